// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FP types and format constants
package fpu_pkg;

    typedef enum logic {
        RM_RNE = 1'b0,
        RM_RTZ = 1'b1
    } rm_e;

    typedef struct packed {
        logic nv;
        logic of;
        logic uf;
        logic nx;
    } flags_t;

    function automatic int max_exp(input int exp_w);
        return (1 << exp_w) - 1;
    endfunction

    // Canonical quiet NaN: sign 0, exponent all ones, only the fraction MSB set
    function automatic logic [63:0] canon_nan(input int exp_w, input int man_w);
        logic [63:0] v;
        v = (64'(max_exp(exp_w)) << man_w) | (64'd1 << (man_w - 1));
        return v;
    endfunction

endpackage

// File: rtl/fpu_lzc.sv
// rtl/fpu_lzc.sv - parametrised leading-zero counter
module fpu_lzc
    import fpu_pkg::*;
#(
    parameter int W = 8,
    localparam int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  value,
    output logic [CW-1:0] count
);

    // Highest set bit wins because it is visited last
    always_comb begin
        count = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (value[i]) begin
                count = CW'(W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fpu_add_pipe.sv
// rtl/fpu_add_pipe.sv - 3-stage IEEE-754 adder/subtractor with valid/ready flow control
module fpu_add_pipe
    import fpu_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [EXP_W+MAN_W:0]   a_i,
    input  logic [EXP_W+MAN_W:0]   b_i,
    input  logic                   op_sub_i,
    input  logic                   rm_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [EXP_W+MAN_W:0]   result_o,
    output logic [3:0]             flags_o
);

    localparam int FW = 1 + EXP_W + MAN_W;
    localparam int SW = MAN_W + 4;          // hidden + fraction + guard/round/sticky
    localparam int XW = EXP_W + 2;
    localparam int LW = $clog2(SW + 1);
    localparam logic [FW-1:0]    QNAN     = FW'(canon_nan(EXP_W, MAN_W));
    localparam logic [XW-1:0]    EMAX     = XW'(max_exp(EXP_W));
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [EXP_W-1:0] EXP_MAXF = EXP_ONES - 1'b1;

    logic en;
    assign en      = ready_i || !valid_o;
    assign ready_o = en;

    // ---------------- S1: unpack, classify, swap, align ----------------
    logic               sa, sb;
    logic [EXP_W-1:0]   ea, eb;
    logic [MAN_W-1:0]   fa, fb;
    logic               a_nan, b_nan, a_inf, b_inf, a_snan, b_snan;
    logic               swap, s_big;
    logic [EXP_W-1:0]   e_big, e_small, ee_big, ee_small, diff;
    logic [MAN_W-1:0]   f_big, f_small;
    logic [MAN_W:0]     sig_big, sig_small;
    logic [2*MAN_W+3:0] align_full;
    logic [SW-1:0]      small_al;
    logic               sp;
    logic [FW-1:0]      sp_res;
    logic               sp_nv;

    assign {sa, ea, fa} = a_i;
    assign sb           = b_i[FW-1] ^ op_sub_i;
    assign {eb, fb}     = b_i[FW-2:0];

    assign a_nan  = (&ea) && (|fa);
    assign b_nan  = (&eb) && (|fb);
    assign a_inf  = (&ea) && !(|fa);
    assign b_inf  = (&eb) && !(|fb);
    assign a_snan = a_nan && !fa[MAN_W-1];
    assign b_snan = b_nan && !fb[MAN_W-1];

    assign swap    = {eb, fb} > {ea, fa};
    assign s_big   = swap ? sb : sa;
    assign e_big   = swap ? eb : ea;
    assign f_big   = swap ? fb : fa;
    assign e_small = swap ? ea : eb;
    assign f_small = swap ? fa : fb;

    assign ee_big    = (e_big == '0) ? EXP_W'(1) : e_big;
    assign ee_small  = (e_small == '0) ? EXP_W'(1) : e_small;
    assign sig_big   = {e_big != '0, f_big};
    assign sig_small = {e_small != '0, f_small};
    assign diff      = ee_big - ee_small;

    // Upper MAN_W+3 bits keep {sig, g, r}; everything below folds into sticky
    assign align_full = {sig_small, {(MAN_W + 3){1'b0}}} >> diff;

    always_comb begin
        if (32'(diff) >= MAN_W + 3) begin
            small_al = {{(SW - 1){1'b0}}, |sig_small};
        end else begin
            small_al = {align_full[2*MAN_W+3:MAN_W+1], |align_full[MAN_W:0]};
        end
    end

    always_comb begin
        sp     = 1'b0;
        sp_res = QNAN;
        sp_nv  = 1'b0;
        if (a_nan || b_nan) begin
            sp    = 1'b1;
            sp_nv = a_snan || b_snan;
        end else if (a_inf && b_inf) begin
            sp = 1'b1;
            if (sa != sb) begin
                sp_nv = 1'b1;
            end else begin
                sp_res = {sa, EXP_ONES, {MAN_W{1'b0}}};
            end
        end else if (a_inf) begin
            sp     = 1'b1;
            sp_res = {sa, EXP_ONES, {MAN_W{1'b0}}};
        end else if (b_inf) begin
            sp     = 1'b1;
            sp_res = {sb, EXP_ONES, {MAN_W{1'b0}}};
        end
    end

    logic             s1_valid, s1_sign, s1_sub, s1_zero_sign, s1_sp, s1_sp_nv;
    logic [EXP_W-1:0] s1_exp;
    logic [SW-1:0]    s1_big, s1_small;
    logic [FW-1:0]    s1_sp_res;
    rm_e              s1_rm;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
        end else if (en) begin
            s1_valid <= valid_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (en) begin
            s1_sign      <= s_big;
            s1_sub       <= sa ^ sb;
            s1_zero_sign <= sa & sb;
            s1_exp       <= ee_big;
            s1_big       <= {sig_big, 3'b000};
            s1_small     <= small_al;
            s1_sp        <= sp;
            s1_sp_res    <= sp_res;
            s1_sp_nv     <= sp_nv;
            s1_rm        <= rm_e'(rm_i);
        end
    end

    // ---------------- S2: significand add/sub ----------------
    logic             s2_valid, s2_sign, s2_zero_sign, s2_sp, s2_sp_nv;
    logic [EXP_W-1:0] s2_exp;
    logic [SW:0]      s2_sum;
    logic [FW-1:0]    s2_sp_res;
    rm_e              s2_rm;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s2_valid <= 1'b0;
        end else if (en) begin
            s2_valid <= s1_valid;
        end
    end

    // Magnitude ordering from S1 guarantees the subtraction never borrows
    always_ff @(posedge clk_i) begin
        if (en) begin
            s2_sum       <= s1_sub ? ({1'b0, s1_big} - {1'b0, s1_small})
                                   : ({1'b0, s1_big} + {1'b0, s1_small});
            s2_sign      <= s1_sign;
            s2_zero_sign <= s1_zero_sign;
            s2_exp       <= s1_exp;
            s2_sp        <= s1_sp;
            s2_sp_res    <= s1_sp_res;
            s2_sp_nv     <= s1_sp_nv;
            s2_rm        <= s1_rm;
        end
    end

    // ---------------- S3: normalise, round, pack ----------------
    logic [LW-1:0]  lz;
    logic [XW-1:0]  e_in, lim, sh, e_n, e_f;
    logic [SW-1:0]  norm;
    logic [MAN_W:0] mant, mant_f;
    logic [MAN_W+1:0] mant_r;
    logic           g, rs, nx, up, tiny, ovf;
    logic [FW-1:0]  res;
    flags_t         fl;

    fpu_lzc #(.W(SW)) u_lzc (
        .value (s2_sum[SW-1:0]),
        .count (lz)
    );

    assign e_in = XW'(s2_exp);
    assign lim  = e_in - XW'(1);

    always_comb begin
        sh = '0;
        if (s2_sum[SW]) begin
            norm = {s2_sum[SW:2], s2_sum[1] | s2_sum[0]};
            e_n  = e_in + XW'(1);
        end else begin
            // Stop at effective exponent 1 so tiny results stay subnormal
            sh   = (XW'(lz) > lim) ? lim : XW'(lz);
            norm = s2_sum[SW-1:0] << sh;
            e_n  = e_in - sh;
        end
    end

    assign mant   = norm[SW-1:3];
    assign g      = norm[2];
    assign rs     = norm[1] | norm[0];
    assign nx     = g | rs;
    assign up     = (s2_rm == RM_RNE) && g && (rs || norm[3]);
    assign mant_r = {1'b0, mant} + {{(MAN_W + 1){1'b0}}, up};

    always_comb begin
        if (mant_r[MAN_W+1]) begin
            mant_f = mant_r[MAN_W+1:1];
            e_f    = e_n + XW'(1);
        end else begin
            mant_f = mant_r[MAN_W:0];
            e_f    = e_n;
        end
    end

    assign tiny = !mant_f[MAN_W];
    assign ovf  = e_f >= EMAX;

    always_comb begin
        fl  = '0;
        res = '0;
        if (s2_sp) begin
            res   = s2_sp_res;
            fl.nv = s2_sp_nv;
        end else if (s2_sum == '0) begin
            res = {s2_zero_sign, {(FW - 1){1'b0}}};
        end else if (ovf) begin
            fl.of = 1'b1;
            fl.nx = 1'b1;
            res   = (s2_rm == RM_RTZ) ? {s2_sign, EXP_MAXF, {MAN_W{1'b1}}}
                                      : {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
        end else begin
            res   = {s2_sign, tiny ? {EXP_W{1'b0}} : e_f[EXP_W-1:0], mant_f[MAN_W-1:0]};
            fl.uf = tiny && nx;
            fl.nx = nx;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o  <= 1'b0;
            result_o <= '0;
            flags_o  <= '0;
        end else if (en) begin
            valid_o  <= s2_valid;
            result_o <= res;
            flags_o  <= fl;
        end
    end

endmodule

// File: tb/tb_fpu_add_pipe.sv
// tb/tb_fpu_add_pipe.sv - directed self-checking bench for fpu_add_pipe
module tb_fpu_add_pipe;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] a_i, b_i;
    logic        op_sub_i;
    logic        rm_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;
    logic [3:0]  flags_o;

    int errors = 0;
    int checks = 0;

    fpu_add_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .a_i      (a_i),
        .b_i      (b_i),
        .op_sub_i (op_sub_i),
        .rm_i     (rm_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .result_o (result_o),
        .flags_o  (flags_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; presents one op, then waits for its result
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic rm,
                         input logic [31:0] er, input logic [3:0] ef);
        int n;
        a_i      = a;
        b_i      = b;
        op_sub_i = sub;
        rm_i     = rm;
        ready_i  = 1'b1;
        valid_i  = 1'b1;
        @(posedge clk_i);
        n = 1;
        @(negedge clk_i);
        valid_i = 1'b0;
        while (!valid_o && n < 10) begin
            @(posedge clk_i);
            n++;
            @(negedge clk_i);
        end
        check({tag, "_lat"}, 32'(n), 32'd3);
        check({tag, "_res"}, result_o, er);
        check({tag, "_flg"}, 32'(flags_o), 32'(ef));
    endtask

    logic [31:0] sa_v [5];
    logic [31:0] sb_v [5];
    logic [31:0] se_v [5];

    initial begin
        int sent, got, c, extra;

        rst_i    = 1'b1;
        valid_i  = 1'b0;
        ready_i  = 1'b0;
        a_i      = '0;
        b_i      = '0;
        op_sub_i = 1'b0;
        rm_i     = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_valid_o", 32'(valid_o), 32'd0);
        check("rst_result_o", result_o, 32'd0);
        check("rst_flags_o", 32'(flags_o), 32'd0);
        check("rst_ready_o", 32'(ready_o), 32'd1);
        rst_i = 1'b0;

        do_op("one_plus_one",  32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 32'h40000000, 4'h0);
        do_op("one_minus_one", 32'h3F800000, 32'h3F800000, 1'b1, 1'b0, 32'h00000000, 4'h0);
        do_op("negz_negz",     32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h80000000, 4'h0);
        do_op("inf_minus_inf", 32'h7F800000, 32'hFF800000, 1'b0, 1'b0, 32'h7FC00000, 4'h8);
        do_op("ovf_rne",       32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 1'b0, 32'h7F800000, 4'h5);
        do_op("ovf_rtz",       32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 1'b1, 32'h7F7FFFFF, 4'h5);
        do_op("tie_even",      32'h3F800000, 32'h33800000, 1'b0, 1'b0, 32'h3F800000, 4'h1);
        do_op("subnorm_exact", 32'h00800000, 32'h00400000, 1'b1, 1'b0, 32'h00400000, 4'h0);
        do_op("snan_in",       32'h7F800001, 32'h3F800000, 1'b0, 1'b0, 32'h7FC00000, 4'h8);
        do_op("inf_plus_one",  32'h7F800000, 32'h3F800000, 1'b0, 1'b0, 32'h7F800000, 4'h0);
        do_op("above_half_rne", 32'h3F800000, 32'h33C00000, 1'b0, 1'b0, 32'h3F800001, 4'h1);
        do_op("above_half_rtz", 32'h3F800000, 32'h33C00000, 1'b0, 1'b1, 32'h3F800000, 4'h1);

        // Back-to-back stream with a 4-cycle downstream stall
        sa_v = '{32'h3F800000, 32'h40000000, 32'h40000000, 32'h40800000, 32'h40400000};
        sb_v = '{32'h3F800000, 32'h3F800000, 32'h40000000, 32'h3F800000, 32'h40400000};
        se_v = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};
        sent = 0;
        got  = 0;
        c    = 0;
        op_sub_i = 1'b0;
        rm_i     = 1'b0;
        while (got < 5 && c < 60) begin
            @(negedge clk_i);
            ready_i = !(c >= 4 && c < 8);
            if (sent < 5) begin
                valid_i = 1'b1;
                a_i     = sa_v[sent];
                b_i     = sb_v[sent];
            end else begin
                valid_i = 1'b0;
            end
            #1;
            if (valid_o && !ready_i) begin
                check("stall_ready_o", 32'(ready_o), 32'd0);
                check("stall_hold_res", result_o, se_v[got]);
                check("stall_hold_flg", 32'(flags_o), 32'd0);
            end
            if (valid_o && ready_i) begin
                check("stream_res", result_o, se_v[got]);
                got++;
            end
            if (valid_i && ready_o) sent++;
            c++;
        end
        check("stream_count", 32'(got), 32'd5);
        valid_i = 1'b0;
        ready_i = 1'b1;
        extra   = 0;
        repeat (6) begin
            @(negedge clk_i);
            if (valid_o) extra++;
        end
        check("stream_dup", 32'(extra), 32'd0);

        // Reset with three ops in flight
        for (int i = 0; i < 3; i++) begin
            valid_i = 1'b1;
            a_i     = sa_v[i];
            b_i     = sb_v[i];
            @(negedge clk_i);
        end
        valid_i = 1'b0;
        ready_i = 1'b0;
        rst_i   = 1'b1;
        @(negedge clk_i);
        check("midrst_valid_o", 32'(valid_o), 32'd0);
        check("midrst_ready_o", 32'(ready_o), 32'd1);
        check("midrst_result_o", result_o, 32'd0);
        rst_i   = 1'b0;
        ready_i = 1'b1;
        extra   = 0;
        repeat (6) begin
            @(negedge clk_i);
            if (valid_o) extra++;
        end
        check("midrst_stale", 32'(extra), 32'd0);
        do_op("after_rst", 32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 32'h40000000, 4'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
